// File: rtl/mem_stage_dcache_pkg.sv
// Shared types and address-field width helpers for the MEM-stage data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2
    } dcache_state_e;

    function automatic int offset_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int index_w(input int lines);
        return $clog2(lines);
    endfunction

    // Byte-offset bits [1:0] are never part of the tag.
    function automatic int tag_w(input int lines, input int words);
        return 30 - offset_w(words) - index_w(lines);
    endfunction

endpackage

// File: rtl/mem_stage_dcache_if.sv
// Word-wide main-memory port of the data cache.
interface mem_stage_dcache_if;
    // Handshake: the cache raises mem_req with mem_we/mem_addr/mem_wdata stable
    // and holds them until memory answers with mem_ack for exactly one cycle per
    // word; mem_rdata is valid only with mem_ack, and mem_ack without mem_req is ignored.
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_stage_dcache_array.sv
// Direct-mapped tag/valid/data storage with combinational read and one word-write port.
module dcache_array #(
    parameter int INDEX_W  = 4,
    parameter int OFFSET_W = 2,
    parameter int TAG_W    = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [INDEX_W-1:0]  index,
    input  logic [OFFSET_W-1:0] rd_offset,
    input  logic                word_we,
    input  logic [OFFSET_W-1:0] wr_offset,
    input  logic [31:0]         wr_word,
    input  logic                fill_we,
    input  logic [TAG_W-1:0]    fill_tag,
    output logic [TAG_W-1:0]    rd_tag,
    output logic                rd_valid,
    output logic [31:0]         rd_word
);
    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = 1 << OFFSET_W;

    logic [31:0]      data_q [LINES][WORDS];
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [LINES-1:0] valid_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (fill_we) begin
            valid_q[index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (word_we) begin
            data_q[index][wr_offset] <= wr_word;
        end
        if (fill_we) begin
            tag_q[index] <= fill_tag;
        end
    end

    assign rd_tag   = tag_q[index];
    assign rd_valid = valid_q[index];
    assign rd_word  = data_q[index][rd_offset];
endmodule

// File: rtl/mem_stage_dcache.sv
// Write-through, no-write-allocate direct-mapped data cache for the MEM stage.
module mem_stage_dcache
    import dcache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [31:0]         addr,
    input  logic [31:0]         write_data,
    output logic                hit,
    output logic [31:0]         read_data,
    output dcache_state_e       state_dbg,
    mem_stage_dcache_if.master  mem
);
    localparam int OFFSET_W = offset_w(WORDS);
    localparam int INDEX_W  = index_w(LINES);
    localparam int TAG_W    = tag_w(LINES, WORDS);

    dcache_state_e       state_q, state_d;
    logic [OFFSET_W-1:0] cnt_q, cnt_d;

    logic [OFFSET_W-1:0] offset;
    logic [INDEX_W-1:0]  index;
    logic [TAG_W-1:0]    tag;
    logic                unused_byte_bits;

    assign offset           = addr[OFFSET_W+1:2];
    assign index            = addr[OFFSET_W+INDEX_W+1:OFFSET_W+2];
    assign tag              = addr[31:OFFSET_W+INDEX_W+2];
    assign unused_byte_bits = ^addr[1:0];

    logic [TAG_W-1:0]    rd_tag;
    logic                rd_valid;
    logic [31:0]         rd_word;
    logic                lookup_hit;
    logic                word_we;
    logic [OFFSET_W-1:0] wr_offset;
    logic [31:0]         wr_word;
    logic                fill_we;
    logic                req, we;
    logic [31:0]         maddr, wdata;

    dcache_array #(
        .INDEX_W (INDEX_W),
        .OFFSET_W(OFFSET_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .index    (index),
        .rd_offset(offset),
        .word_we  (word_we),
        .wr_offset(wr_offset),
        .wr_word  (wr_word),
        .fill_we  (fill_we),
        .fill_tag (tag),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .rd_word  (rd_word)
    );

    assign lookup_hit = rd_valid && (rd_tag == tag);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Everything is gated by rst_n so reset also silences the outputs combinationally.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hit       = 1'b0;
        read_data = '0;
        req       = 1'b0;
        we        = 1'b0;
        maddr     = '0;
        wdata     = '0;
        word_we   = 1'b0;
        wr_offset = offset;
        wr_word   = write_data;
        fill_we   = 1'b0;
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    if (mem_write) begin
                        state_d = WRITE;
                    end else if (mem_read) begin
                        if (lookup_hit) begin
                            hit       = 1'b1;
                            read_data = rd_word;
                        end else begin
                            state_d = REFILL;
                            cnt_d   = '0;
                        end
                    end else begin
                        hit = 1'b1;
                    end
                end
                REFILL: begin
                    req   = 1'b1;
                    maddr = {addr[31:OFFSET_W+2], cnt_q, 2'b00};
                    if (mem.mem_ack) begin
                        word_we   = 1'b1;
                        wr_offset = cnt_q;
                        wr_word   = mem.mem_rdata;
                        cnt_d     = cnt_q + 1'b1;
                        // Valid only on the last word so a partial line never hits.
                        if (cnt_q == OFFSET_W'(WORDS - 1)) begin
                            fill_we = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                WRITE: begin
                    req   = 1'b1;
                    we    = 1'b1;
                    maddr = {addr[31:2], 2'b00};
                    wdata = write_data;
                    if (mem.mem_ack) begin
                        hit     = 1'b1;
                        word_we = lookup_hit;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign mem.mem_req   = req;
    assign mem.mem_we    = we;
    assign mem.mem_addr  = maddr;
    assign mem.mem_wdata = wdata;
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_mem_stage_dcache.sv
// Directed bench for mem_stage_dcache against a programmable-latency memory model.
module tb_mem_stage_dcache;
    import dcache_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_read, mem_write;
    logic [31:0]   addr, write_data;
    logic          hit;
    logic [31:0]   read_data;
    dcache_state_e state_dbg;

    mem_stage_dcache_if bus();

    mem_stage_dcache #(.LINES(16), .WORDS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .write_data(write_data),
        .hit       (hit),
        .read_data (read_data),
        .state_dbg (state_dbg),
        .mem       (bus.master)
    );

    // clock / reset
    always #5 clk = ~clk;

    // memory model: ack after ack_delay request cycles, data = data_base + word index
    int          ack_delay = 0;
    int          wait_cnt  = 0;
    logic [31:0] data_base = 32'h1000;
    int          rd_acks   = 0;
    int          wr_acks   = 0;

    assign bus.mem_ack   = bus.mem_req && (wait_cnt == ack_delay);
    assign bus.mem_rdata = data_base + {28'd0, bus.mem_addr[3:2]};

    always @(posedge clk) begin
        if (!bus.mem_req || bus.mem_ack) wait_cnt <= 0;
        else                             wait_cnt <= wait_cnt + 1;
        if (bus.mem_req && bus.mem_ack) begin
            if (bus.mem_we) wr_acks <= wr_acks + 1;
            else            rd_acks <= rd_acks + 1;
        end
    end

    // scoreboard counters
    int n_checks = 0;
    int n_fail   = 0;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            assert (!(mem_read && mem_write)) else begin
                n_fail++;
                $error("FAIL illegal_rw observed=read&write expected=exclusive");
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // driver tasks: drive just after posedge, sample on negedge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic wait_hit(output int cycles);
        cycles = 0;
        while (hit !== 1'b1 && cycles < 30) begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
        end
    endtask

    int cyc;
    int saved_rd, saved_wr;

    initial begin
        rst_n      = 1'b0;
        mem_read   = 1'b1;
        mem_write  = 1'b0;
        addr       = 32'h40;
        write_data = '0;
        repeat (2) @(posedge clk);
        sample();
        check("rst_hit",       {31'd0, hit},          32'd0);
        check("rst_read_data", read_data,             32'd0);
        check("rst_mem_req",   {31'd0, bus.mem_req},  32'd0);
        check("rst_mem_addr",  bus.mem_addr,          32'd0);
        check("rst_state",     {30'd0, state_dbg},    {30'd0, IDLE});

        // 1: cold read miss of 0x40, zero-wait refill
        next_cycle();
        rst_n = 1'b1;
        sample();
        check("s1_miss_hit", {31'd0, hit},         32'd0);
        check("s1_miss_req", {31'd0, bus.mem_req}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            sample();
            check("s1_refill_hit",  {31'd0, hit},         32'd0);
            check("s1_refill_req",  {31'd0, bus.mem_req}, 32'd1);
            check("s1_refill_we",   {31'd0, bus.mem_we},  32'd0);
            check("s1_refill_addr", bus.mem_addr,         32'h40 + 32'(4 * k));
        end
        next_cycle();
        sample();
        check("s1_hit",  {31'd0, hit}, 32'd1);
        check("s1_data", read_data,    32'h1000);

        // 2: read hit on the filled line
        next_cycle();
        addr = 32'h48;
        sample();
        check("s2_hit",  {31'd0, hit},         32'd1);
        check("s2_data", read_data,            32'h1002);
        check("s2_req",  {31'd0, bus.mem_req}, 32'd0);

        // 3: store hit with delayed ack
        next_cycle();
        mem_read   = 1'b0;
        mem_write  = 1'b1;
        addr       = 32'h44;
        write_data = 32'hDEADBEEF;
        ack_delay  = 2;
        sample();
        check("s3_idle_hit", {31'd0, hit}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            sample();
            check("s3_wait_hit", {31'd0, hit},        32'd0);
            check("s3_we",       {31'd0, bus.mem_we}, 32'd1);
            check("s3_addr",     bus.mem_addr,        32'h44);
            check("s3_wdata",    bus.mem_wdata,       32'hDEADBEEF);
        end
        next_cycle();
        sample();
        check("s3_ack_hit", {31'd0, hit}, 32'd1);
        next_cycle();
        mem_write = 1'b0;
        mem_read  = 1'b1;
        ack_delay = 0;
        sample();
        check("s3_read_hit",  {31'd0, hit},         32'd1);
        check("s3_read_data", read_data,            32'hDEADBEEF);
        check("s3_read_req",  {31'd0, bus.mem_req}, 32'd0);

        // 4: store miss does not allocate; following read refills
        next_cycle();
        mem_read   = 1'b0;
        mem_write  = 1'b1;
        addr       = 32'h2000;
        write_data = 32'h12345678;
        saved_rd   = rd_acks;
        saved_wr   = wr_acks;
        sample();
        check("s4_store_idle_hit", {31'd0, hit}, 32'd0);
        next_cycle();
        sample();
        check("s4_store_ack_hit", {31'd0, hit}, 32'd1);
        check("s4_store_addr",    bus.mem_addr, 32'h2000);
        next_cycle();
        mem_write = 1'b0;
        mem_read  = 1'b1;
        data_base = 32'h7000;
        check("s4_no_refill",  32'(rd_acks - saved_rd), 32'd0);
        check("s4_one_write",  32'(wr_acks - saved_wr), 32'd1);
        sample();
        check("s4_read_miss", {31'd0, hit}, 32'd0);
        wait_hit(cyc);
        check("s4_latency",   32'(cyc),                 32'd5);
        check("s4_refills",   32'(rd_acks - saved_rd),  32'd4);
        check("s4_data",      read_data,                32'h7000);

        // 5: conflict on index 4 evicts 0x40's line
        next_cycle();
        addr      = 32'h440;
        data_base = 32'h5000;
        sample();
        check("s5_conf_miss", {31'd0, hit}, 32'd0);
        wait_hit(cyc);
        check("s5_conf_latency", 32'(cyc), 32'd5);
        check("s5_conf_data",    read_data, 32'h5000);
        next_cycle();
        addr      = 32'h40;
        data_base = 32'h6000;
        sample();
        check("s5_evict_miss", {31'd0, hit}, 32'd0);
        wait_hit(cyc);
        check("s5_evict_latency", 32'(cyc), 32'd5);
        check("s5_evict_data",    read_data, 32'h6000);

        // 6: reset during the second refill word
        next_cycle();
        addr      = 32'h80;
        data_base = 32'h9000;
        sample();
        check("s6_miss", {31'd0, hit}, 32'd0);
        next_cycle();
        sample();
        check("s6_word0_addr", bus.mem_addr, 32'h80);
        next_cycle();
        rst_n = 1'b0;
        sample();
        check("s6_rst_req", {31'd0, bus.mem_req}, 32'd0);
        check("s6_rst_hit", {31'd0, hit},         32'd0);
        next_cycle();
        rst_n    = 1'b1;
        saved_rd = rd_acks;
        sample();
        check("s6_post_state", {30'd0, state_dbg},    {30'd0, IDLE});
        check("s6_post_req",   {31'd0, bus.mem_req},  32'd0);
        check("s6_post_miss",  {31'd0, hit},          32'd0);
        wait_hit(cyc);
        check("s6_latency", 32'(cyc),                32'd5);
        check("s6_refills", 32'(rd_acks - saved_rd), 32'd4);
        check("s6_data",    read_data,               32'h9000);

        next_cycle();
        mem_read = 1'b0;
        sample();
        check("idle_hit", {31'd0, hit}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
